// File: rtl/af_relay_ctrl_if.sv
// Port bundle for af_relay_ctrl: quality-sample input side and relay-decision output side.
// q_valid has no ready partner: the controller accepts q_in on every enabled cycle where q_valid is 1.
interface af_relay_ctrl_if;
  logic       ena;
  logic       q_valid;
  logic [7:0] q_in;
  logic       force_direct;
  logic       relay_on;
  logic [1:0] mode;
  logic [7:0] q_avg;
  logic       switch_pulse;

  modport master (
    output ena, q_valid, q_in, force_direct,
    input  relay_on, mode, q_avg, switch_pulse
  );

  modport slave (
    input  ena, q_valid, q_in, force_direct,
    output relay_on, mode, q_avg, switch_pulse
  );
endinterface

// File: rtl/af_relay_ctrl.sv
// AF relay decision controller: averaged link quality, hysteresis thresholds and dwell timing.
// Build option AF_RELAY_EMA_EN enables the EMA filter; otherwise q_avg tracks the latest sample.
module af_relay_ctrl #(
  parameter int HI_TH     = 144,
  parameter int LO_TH     = 112,
  parameter int DWELL     = 16,
  parameter int AVG_SHIFT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  af_relay_ctrl_if.slave bus
);

  localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [7:0]      HI       = 8'(HI_TH);
  localparam logic [7:0]      LO       = 8'(LO_TH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

  if (AVG_SHIFT < 0 || AVG_SHIFT > 7 || LO_TH > HI_TH || DWELL < 1 || DWELL > 256) begin : g_bad_params
    $error("af_relay_ctrl: parameter out of range");
  end

  // State codes double as the mode output.
  typedef enum logic [1:0] {
    S_DIRECT  = 2'b00,
    S_ARM     = 2'b10,
    S_AF      = 2'b01,
    S_RELEASE = 2'b11
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    avg;
  logic [7:0]    avg_next;
  logic          relay_on_q;
  logic          pulse_q;

`ifdef AF_RELAY_EMA_EN
  logic signed [8:0] diff;
  logic signed [8:0] step;

  // Floor rounding of the arithmetic shift keeps avg inside 0..255 without saturation.
  always_comb begin
    diff     = $signed({1'b0, bus.q_in}) - $signed({1'b0, avg});
    step     = diff >>> AVG_SHIFT;
    avg_next = 8'($signed({1'b0, avg}) + step);
  end
`else
  always_comb begin
    avg_next = bus.q_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DIRECT;
      cnt        <= '0;
      avg        <= '0;
      relay_on_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else if (!bus.ena) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (bus.q_valid) avg <= avg_next;
      // Decisions below use avg as it stood before this edge.
      if (bus.force_direct) begin
        state      <= S_DIRECT;
        cnt        <= '0;
        relay_on_q <= 1'b0;
        pulse_q    <= relay_on_q;
      end else begin
        case (state)
          S_DIRECT: begin
            if (avg >= HI) begin
              state <= S_ARM;
              cnt   <= '0;
            end
          end
          S_ARM: begin
            if (avg < HI) begin
              state <= S_DIRECT;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state      <= S_AF;
              cnt        <= '0;
              relay_on_q <= 1'b1;
              pulse_q    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_AF: begin
            if (avg < LO) begin
              state <= S_RELEASE;
              cnt   <= '0;
            end
          end
          S_RELEASE: begin
            if (avg >= LO) begin
              state <= S_AF;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state      <= S_DIRECT;
              cnt        <= '0;
              relay_on_q <= 1'b0;
              pulse_q    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state      <= S_DIRECT;
            cnt        <= '0;
            relay_on_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mode         = state;
  assign bus.relay_on     = relay_on_q;
  assign bus.q_avg        = avg;
  assign bus.switch_pulse = pulse_q;

endmodule

// File: tb/tb_af_relay_ctrl.sv
// Directed bench for af_relay_ctrl with default parameters; expectations follow the
// AF_RELAY_EMA_EN build setting (filtered ramp vs. direct sample tracking).
module tb_af_relay_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  af_relay_ctrl_if bus ();

  af_relay_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef AF_RELAY_EMA_EN
  localparam int ARM_E = 6;
  localparam logic [7:0] RAMP [0:4] = '{8'd50, 8'd87, 8'd115, 8'd136, 8'd152};
`else
  localparam int ARM_E = 2;
`endif
  localparam int AF_E = ARM_E + 16;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_avg;
  logic [7:0] ramp_v;

`ifdef AF_RELAY_EMA_EN
  function automatic logic [7:0] ema_step(input logic [7:0] a, input logic [7:0] q);
    int d;
    d = int'(q) - int'(a);
    d = d >>> 2;
    return 8'(int'(a) + d);
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && bus.ena && bus.q_valid) begin
`ifdef AF_RELAY_EMA_EN
      exp_avg = ema_step(exp_avg, bus.q_in);
`else
      exp_avg = bus.q_in;
`endif
    end
    #2;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.ena          = 1'b0;
    bus.q_valid      = 1'b0;
    bus.q_in         = 8'd0;
    bus.force_direct = 1'b0;
    exp_avg          = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_relay"}, 32'(bus.relay_on), 0);
    chk({tag, "_mode"}, 32'(bus.mode), 0);
    chk({tag, "_avg"}, 32'(bus.q_avg), 0);
    chk({tag, "_pulse"}, 32'(bus.switch_pulse), 0);
  endtask

  initial begin
    // Reset
    rst_n            = 1'b0;
    bus.ena          = 1'b0;
    bus.q_valid      = 1'b0;
    bus.q_in         = 8'd0;
    bus.force_direct = 1'b0;
    exp_avg          = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Ramp to AF
    bus.ena = 1'b1; bus.q_valid = 1'b1; bus.q_in = 8'd200;
    for (int e = 1; e <= AF_E; e++) begin
      tick();
      if (e <= 5) begin
`ifdef AF_RELAY_EMA_EN
        ramp_v = RAMP[e-1];
`else
        ramp_v = 8'd200;
`endif
        chk($sformatf("ramp_avg_e%0d", e), 32'(bus.q_avg), 32'(ramp_v));
      end
      chk($sformatf("ramp_mode_e%0d", e), 32'(bus.mode),
          (e < ARM_E) ? 32'd0 : (e < AF_E) ? 32'd2 : 32'd1);
      chk($sformatf("ramp_pulse_e%0d", e), 32'(bus.switch_pulse), (e == AF_E) ? 32'd1 : 32'd0);
      chk($sformatf("ramp_relay_e%0d", e), 32'(bus.relay_on), (e == AF_E) ? 32'd1 : 32'd0);
    end
    tick();
    chk("ramp_pulse_after", 32'(bus.switch_pulse), 0);
    chk("ramp_relay_after", 32'(bus.relay_on), 1);

    // Hysteresis hold at 120
    bus.q_in = 8'd120;
    for (int e = 1; e <= 40; e++) begin
      tick();
      chk($sformatf("hyst_mode_e%0d", e), 32'(bus.mode), 1);
    end
    chk("hyst_avg", 32'(bus.q_avg), 120);
    chk("hyst_relay", 32'(bus.relay_on), 1);

    // Release to DIRECT
    bus.q_in = 8'd0;
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 1) chk("rel_avg_e1", 32'(bus.q_avg), 32'(exp_avg));
      chk($sformatf("rel_mode_e%0d", e), 32'(bus.mode),
          (e < 2) ? 32'd1 : (e < 18) ? 32'd3 : 32'd0);
      chk($sformatf("rel_relay_e%0d", e), 32'(bus.relay_on), (e < 18) ? 32'd1 : 32'd0);
      chk($sformatf("rel_pulse_e%0d", e), 32'(bus.switch_pulse), (e == 18) ? 32'd1 : 32'd0);
    end

    // Force direct from AF
    do_reset();
    bus.ena = 1'b1; bus.q_valid = 1'b1; bus.q_in = 8'd200;
    repeat (AF_E) tick();
    chk("force_pre_mode", 32'(bus.mode), 1);
    bus.force_direct = 1'b1;
    tick();
    bus.force_direct = 1'b0;
    chk("force_mode", 32'(bus.mode), 0);
    chk("force_relay", 32'(bus.relay_on), 0);
    chk("force_pulse", 32'(bus.switch_pulse), 1);
    tick();
    chk("force_rearm_mode", 32'(bus.mode), 2);
    chk("force_rearm_pulse", 32'(bus.switch_pulse), 0);

    // Abort during arming
    do_reset();
    bus.ena = 1'b1; bus.q_valid = 1'b1; bus.q_in = 8'd200;
    repeat (ARM_E) tick();
    chk("abort_arm_mode", 32'(bus.mode), 2);
    chk("abort_arm_avg", 32'(bus.q_avg), 32'(exp_avg));
    bus.q_in = 8'd0;
    tick();
    chk("abort_e1_mode", 32'(bus.mode), 2);
    chk("abort_e1_pulse", 32'(bus.switch_pulse), 0);
    tick();
    chk("abort_e2_mode", 32'(bus.mode), 0);
    chk("abort_e2_pulse", 32'(bus.switch_pulse), 0);
    chk("abort_e2_relay", 32'(bus.relay_on), 0);

    // Freeze during ARM, then resume and finish the dwell
    do_reset();
    bus.ena = 1'b1; bus.q_valid = 1'b1; bus.q_in = 8'd200;
    repeat (ARM_E + 3) tick();
    chk("freeze_pre_mode", 32'(bus.mode), 2);
    bus.ena = 1'b0; bus.q_in = 8'd0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("freeze_mode_e%0d", e), 32'(bus.mode), 2);
      chk($sformatf("freeze_avg_e%0d", e), 32'(bus.q_avg), 32'(exp_avg));
      chk($sformatf("freeze_pulse_e%0d", e), 32'(bus.switch_pulse), 0);
    end
    bus.ena = 1'b1; bus.q_in = 8'd200;
    repeat (12) tick();
    chk("freeze_cnt_hold_mode", 32'(bus.mode), 2);
    tick();
    chk("freeze_af_mode", 32'(bus.mode), 1);
    chk("freeze_af_pulse", 32'(bus.switch_pulse), 1);

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/af_relay_ctrl.md
# af_relay_ctrl

Sequential controller for the amplify-and-forward (AF) relay decision. It smooths the incoming link-quality metric with an exponential moving average and applies hysteresis thresholds plus a minimum dwell time before switching between direct-link and AF modes. This keeps the relay from chattering when quality hovers near a single threshold. It sits between the quality-metric source (`ui_in`) and the relay-enable / mode outputs (`uo_out`) in the Tiny Tapeout top level.

## Interface
- `HI_TH`, default 144: averaged-quality level that starts arming AF.
- `LO_TH`, default 112: averaged-quality level below which release starts. Must satisfy `LO_TH <= HI_TH`.
- `DWELL`, default 16: enabled cycles the condition must persist before a switch (1..256).
- `AVG_SHIFT`, default 2: EMA weight, 2^-AVG_SHIFT (0..7).
- `clk`, in, 1: clock; all state is updated on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `ena`, in, 1: clock enable; when 0, all state is frozen.
- `q_valid`, in, 1: `q_in` carries a new sample this cycle.
- `q_in`, in, 8: link-quality sample, unsigned 0..255.
- `force_direct`, in, 1: forces direct mode; has highest priority.
- `relay_on`, out, 1: 1 = AF path enabled.
- `mode`, out, 2: state code (00 DIRECT, 10 ARM, 01 AF, 11 RELEASE).
- `q_avg`, out, 8: current averaged quality.
- `switch_pulse`, out, 1: one-cycle strobe on every `relay_on` change.

## Operation
- **Reset values.** `q_avg`=0, state DIRECT, dwell counter=0, `relay_on`=0, `mode`=00, `switch_pulse`=0. All outputs are registered.
- **Average update.** On `ena & q_valid`:
  - diff = {0,q_in} − {0,avg}, computed as 9-bit signed.
  - avg ← avg + (diff >>> AVG_SHIFT), using an arithmetic shift.
  - The result always stays within 0..255; no saturation is needed.
  - Rounding is toward −inf, so a rising avg may settle up to 2^AVG_SHIFT−1 below `q_in`. This is accepted behaviour.
- **State transitions** are evaluated every `ena` cycle against the registered avg (the value before this edge's update):
  - DIRECT: avg ≥ HI_TH → ARM, counter cleared.
  - ARM:
    - avg < HI_TH → DIRECT, no pulse.
    - Else if cnt == DWELL−1 → AF, `switch_pulse`=1.
    - Else cnt++.
  - AF: avg < LO_TH → RELEASE, counter cleared. Avg in [LO_TH, HI_TH) holds AF.
  - RELEASE:
    - avg ≥ LO_TH → AF, no pulse.
    - Else if cnt == DWELL−1 → DIRECT, `switch_pulse`=1.
    - Else cnt++.
- **`force_direct`** (with `ena`=1): next state is DIRECT and the counter is cleared.
  - From AF or RELEASE, `switch_pulse`=1.
  - From DIRECT or ARM, no pulse.
- **`relay_on`** is 1 in AF and RELEASE, and 0 in DIRECT and ARM.
- **`ena`=0**: avg, state and counter hold; `switch_pulse` is driven 0.
- **Counter** is ceil(log2(DWELL)) bits (minimum 1) and never wraps, because it is cleared on every state entry.

## Timing
- A sample accepted at edge N is visible on `q_avg` after edge N. It can change state at edge N+1 at the earliest.
- An ARM or RELEASE state lasts exactly DWELL enabled cycles when the condition holds throughout.
- `switch_pulse` is high for the single cycle following the edge that changes `relay_on`, aligned with the new `relay_on` value.
- Asserting `rst_n` low mid-operation immediately forces all reset values, regardless of `clk`.
- `force_direct` takes effect at the next `ena` edge (1-cycle latency).

## Configuration
- Macro: `AF_RELAY_EMA_EN`.
- **Defined:** the EMA filter operates as described above.
- **Undefined:**
  - avg ← q_in on each `ena & q_valid`; `AVG_SHIFT` is ignored and no filter adder is built.
  - Hysteresis and dwell logic are unchanged.

## Test plan
All scenarios use the default parameters.
- **Reset.** Drive `rst_n`=0 for 2 cycles, then 1. Required: `relay_on`=0, `mode`=00, `q_avg`=0, `switch_pulse`=0.
- **Ramp to AF.** Hold `ena`=1, `q_valid`=1, `q_in`=200 from edge 1.
  - `q_avg` sequence: 50, 87, 115, 136, 152.
  - ARM is entered at edge 6.
  - AF is entered at edge 22, with `relay_on`=1 and a single `switch_pulse`.
- **Abort during arming.** In ARM with `q_avg`=152, drive `q_in`=0 until avg < 144. Required: return to DIRECT and no `switch_pulse`.
- **Hysteresis hold.** In AF, drive `q_in`=120. Required: `q_avg` converges near 120 and the state stays AF indefinitely. Then drive `q_in`=0: RELEASE follows, and DIRECT is reached 16 cycles later with a pulse.
- **Force direct.** In AF, pulse `force_direct` for 1 cycle. Required: next edge gives `mode`=00, `relay_on`=0, `switch_pulse`=1.
- **Freeze and reset.** During ARM, hold `ena`=0 for 10 cycles: state, counter and `q_avg` are unchanged. Then assert `rst_n`=0 mid-cycle: outputs go to reset values without waiting for a clock edge.
